// File: rtl/mnist_pkg.sv
// Shared constants, FSM state encoding and score type for the MNIST argmax back-end.
package mnist_pkg;

  localparam int N           = 8;
  localparam int NUM_CLASSES = 10;
  localparam int CLASS_W     = $clog2(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [N-1:0] score_t;

endpackage

// File: rtl/mnist_argmax_if.sv
// Score-vector input and class-result output bundle for mnist_argmax.
// MNIST_ARGMAX_TOP2_EN adds the runner-up class and margin signals.
interface mnist_argmax_if #(
  parameter int N           = mnist_pkg::N,
  parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
  parameter int CLASS_W     = mnist_pkg::CLASS_W
);

  logic                     in_vld;
  logic [NUM_CLASSES*N-1:0] in_din;
  logic                     out_vld;
  logic                     out_rdy;
  logic [CLASS_W-1:0]       out_class;
  logic [N-1:0]             out_score;
`ifdef MNIST_ARGMAX_TOP2_EN
  logic [CLASS_W-1:0]       out_class2;
  logic [N:0]               out_margin;

  modport master (
    output in_vld, in_din, out_rdy,
    input  out_vld, out_class, out_score, out_class2, out_margin
  );
  modport slave (
    input  in_vld, in_din, out_rdy,
    output out_vld, out_class, out_score, out_class2, out_margin
  );
`else
  modport master (
    output in_vld, in_din, out_rdy,
    input  out_vld, out_class, out_score
  );
  modport slave (
    input  in_vld, in_din, out_rdy,
    output out_vld, out_class, out_score
  );
`endif

endinterface

// File: rtl/mnist_argmax_cmp.sv
// Combinational signed compare-and-select of a candidate lane against a reference {score, idx}.
module mnist_argmax_cmp #(
  parameter int N       = 8,
  parameter int CLASS_W = 4
) (
  input  logic signed [N-1:0]  cand_score,
  input  logic [CLASS_W-1:0]   cand_idx,
  input  logic signed [N-1:0]  ref_score,
  input  logic [CLASS_W-1:0]   ref_idx,
  output logic                 take,
  output logic signed [N-1:0]  sel_score,
  output logic [CLASS_W-1:0]   sel_idx
);

  // Strict compare: an equal candidate never displaces the earlier (lower) index.
  assign take      = cand_score > ref_score;
  assign sel_score = take ? cand_score : ref_score;
  assign sel_idx   = take ? cand_idx : ref_idx;

endmodule

// File: rtl/mnist_argmax.sv
// Captures a 10-lane logit vector, scans it serially for the maximum, and holds the result on a valid/ready port.
// MNIST_ARGMAX_TOP2_EN additionally tracks the runner-up class and the best-minus-second margin.
module mnist_argmax
  import mnist_pkg::*;
#(
  parameter int N           = mnist_pkg::N,
  parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
  parameter int CLASS_W     = mnist_pkg::CLASS_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  mnist_argmax_if.slave bus,
  output logic          busy,
  output logic          drop_err
);

  state_t              state, state_nxt;
  logic signed [N-1:0] vec_q [NUM_CLASSES];
  logic [CLASS_W-1:0]  idx, best_idx, sel_idx;
  logic signed [N-1:0] best_score, sel_score, lane;
  logic                take, hs, capture, last;

  assign lane    = vec_q[idx];
  assign last    = (idx == CLASS_W'(NUM_CLASSES - 1));
  assign hs      = (state == DONE) && bus.out_rdy;
  // A handshake in DONE frees the block on the same edge, so a new vector may land with no bubble.
  assign capture = ce && bus.in_vld && ((state == IDLE) || hs);

  mnist_argmax_cmp #(.N(N), .CLASS_W(CLASS_W)) u_cmp_best (
    .cand_score (lane),
    .cand_idx   (idx),
    .ref_score  (best_score),
    .ref_idx    (best_idx),
    .take       (take),
    .sel_score  (sel_score),
    .sel_idx    (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ce) begin
      case (state)
        IDLE:    if (bus.in_vld) state_nxt = SCAN;
        SCAN:    if (last) state_nxt = DONE;
        DONE:    if (bus.out_rdy) state_nxt = bus.in_vld ? SCAN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) vec_q[k] <= '0;
      idx        <= '0;
      best_score <= '0;
      best_idx   <= '0;
    end else if (ce) begin
      if (capture) begin
        for (int k = 0; k < NUM_CLASSES; k++) vec_q[k] <= bus.in_din[k*N +: N];
        best_score <= bus.in_din[N-1:0];
        best_idx   <= '0;
        idx        <= CLASS_W'(1);
      end else if (state == SCAN) begin
        best_score <= sel_score;
        best_idx   <= sel_idx;
        idx        <= last ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_err <= 1'b0;
    else if (ce && bus.in_vld && ((state == SCAN) || ((state == DONE) && !bus.out_rdy)))
      drop_err <= 1'b1;
  end

  assign busy          = (state != IDLE);
  assign bus.out_vld   = (state == DONE);
  assign bus.out_class = best_idx;
  assign bus.out_score = best_score;

`ifdef MNIST_ARGMAX_TOP2_EN
  logic signed [N-1:0] sec_score, sec_sel_score;
  logic [CLASS_W-1:0]  sec_idx, sec_sel_idx;
  logic                sec_vld, sec_take;

  mnist_argmax_cmp #(.N(N), .CLASS_W(CLASS_W)) u_cmp_sec (
    .cand_score (lane),
    .cand_idx   (idx),
    .ref_score  (sec_score),
    .ref_idx    (sec_idx),
    .take       (sec_take),
    .sel_score  (sec_sel_score),
    .sel_idx    (sec_sel_idx)
  );

  // sec_vld marks the runner-up as empty until the first non-winning lane (or a demoted best) fills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_score <= '0;
      sec_idx   <= '0;
      sec_vld   <= 1'b0;
    end else if (ce) begin
      if (capture) begin
        sec_score <= '0;
        sec_idx   <= '0;
        sec_vld   <= 1'b0;
      end else if (state == SCAN) begin
        if (take) begin
          sec_score <= best_score;
          sec_idx   <= best_idx;
          sec_vld   <= 1'b1;
        end else if (!sec_vld) begin
          sec_score <= lane;
          sec_idx   <= idx;
          sec_vld   <= 1'b1;
        end else if (sec_take) begin
          sec_score <= sec_sel_score;
          sec_idx   <= sec_sel_idx;
        end
      end
    end
  end

  assign bus.out_class2 = sec_idx;
  assign bus.out_margin = {best_score[N-1], best_score} - {sec_score[N-1], sec_score};
`endif

endmodule

// File: tb/tb_mnist_argmax.sv
// Scoreboard bench for mnist_argmax: stimulus pushes reference results, a negedge monitor pops and compares.
// Runner-up checks are compiled in when MNIST_ARGMAX_TOP2_EN is defined.
`timescale 1ns/1ps
module tb_mnist_argmax;
  import mnist_pkg::*;

  localparam int W = NUM_CLASSES * N;

  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic [N-1:0]       score;
    logic [CLASS_W-1:0] cls2;
    logic [N:0]         margin;
  } exp_t;

  logic clk = 1'b0;
  logic rst, ce, busy, drop_err;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  mnist_argmax_if #(.N(N), .NUM_CLASSES(NUM_CLASSES), .CLASS_W(CLASS_W)) bus ();

  mnist_argmax #(.N(N), .NUM_CLASSES(NUM_CLASSES), .CLASS_W(CLASS_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .bus      (bus),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value-level max, then lowest index holding it; runner-up is the same over the remaining lanes.
  function automatic exp_t model(input logic [W-1:0] v);
    int   s [NUM_CLASSES];
    int   mx, m2, b, b2;
    exp_t e;
    for (int k = 0; k < NUM_CLASSES; k++) s[k] = int'($signed(v[k*N +: N]));
    mx = s[0];
    for (int k = 1; k < NUM_CLASSES; k++) if (s[k] > mx) mx = s[k];
    b = -1;
    for (int k = 0; k < NUM_CLASSES; k++) if (b == -1 && s[k] == mx) b = k;
    m2 = -1000000;
    for (int k = 0; k < NUM_CLASSES; k++) if (k != b && s[k] > m2) m2 = s[k];
    b2 = -1;
    for (int k = 0; k < NUM_CLASSES; k++) if (k != b && b2 == -1 && s[k] == m2) b2 = k;
    e.cls    = CLASS_W'(b);
    e.score  = N'(mx);
    e.cls2   = CLASS_W'(b2);
    e.margin = (N+1)'(mx - m2);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_vld) begin
      if (sb.size() == 0) begin
        check("unexpected_vld", {31'd0, bus.out_vld}, 32'd0);
      end else begin
        check("class", {28'd0, bus.out_class}, {28'd0, sb[0].cls});
        check("score", {24'd0, bus.out_score}, {24'd0, sb[0].score});
`ifdef MNIST_ARGMAX_TOP2_EN
        check("class2", {28'd0, bus.out_class2}, {28'd0, sb[0].cls2});
        check("margin", {23'd0, bus.out_margin}, {23'd0, sb[0].margin});
`endif
        if (ce && bus.out_rdy) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, input bit push);
    bus.in_din = v;
    bus.in_vld = 1'b1;
    if (push) sb.push_back(model(v));
    tick();
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.out_vld) break;
      if (n >= 200) begin
        total++; bad++;
        $display("FAIL vld_timeout: got no out_vld after %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic drain();
    int g = 0;
    bus.out_rdy = 1'b1;
    while ((sb.size() != 0 || busy) && g < 500) begin
      tick();
      g++;
    end
    if (g >= 500) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] v, v2;
    int n, sent, guard;

    rst = 1'b1; ce = 1'b1;
    bus.in_vld = 1'b0; bus.in_din = '0; bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_vld", {31'd0, bus.out_vld}, 32'd0);
    check("rst_out_class", {28'd0, bus.out_class}, 32'd0);
    check("rst_out_score", {24'd0, bus.out_score}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop_err", {31'd0, drop_err}, 32'd0);
`ifdef MNIST_ARGMAX_TOP2_EN
    check("rst_out_class2", {28'd0, bus.out_class2}, 32'd0);
    check("rst_out_margin", {23'd0, bus.out_margin}, 32'd0);
`endif
    tick();
    rst = 1'b0;

    // Ramp lanes: latency from capture edge to first visible out_vld.
    bus.out_rdy = 1'b1;
    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = N'(k);
    send(v, 1'b1);
    wait_vld(n);
    check("latency", n, NUM_CLASSES);
    drain();

    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = (k == 3) ? N'(-1) : N'(-128);
    send(v, 1'b1);
    drain();

    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = N'($urandom_range(0, 254) - 128);
    v[2*N +: N] = N'(127);
    v[7*N +: N] = N'(127);
    send(v, 1'b1);
    drain();

    // Random vectors, random ready, new vectors offered on handshake cycles.
    sent = 0; guard = 0;
    while ((sent < 40 || sb.size() != 0) && guard < 5000) begin
      bus.in_vld  = 1'b0;
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      if (sent < 40 && (!busy || (bus.out_vld && bus.out_rdy))) begin
        for (int k = 0; k < NUM_CLASSES; k++)
          v[k*N +: N] = (sent % 3 == 0) ? N'($urandom_range(0, 3)) : N'($urandom);
        bus.in_din = v;
        bus.in_vld = 1'b1;
        sb.push_back(model(v));
        sent++;
      end
      tick();
      guard++;
    end
    bus.in_vld = 1'b0;
    if (guard >= 5000) begin
      total++; bad++;
      $display("FAIL random_timeout: got %0d pending expected 0", sb.size());
    end
    drain();
    check("random_no_drop", {31'd0, drop_err}, 32'd0);

    // Back-to-back: second vector on the handshake cycle.
    bus.out_rdy = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = N'($urandom);
    send(v, 1'b1);
    wait_vld(n);
    tick();
    bus.out_rdy = 1'b1;
    for (int k = 0; k < NUM_CLASSES; k++) v2[k*N +: N] = N'($urandom);
    send(v2, 1'b1);
    wait_vld(n);
    check("b2b_latency", n, NUM_CLASSES);
    check("b2b_no_drop", {31'd0, drop_err}, 32'd0);
    drain();

    // Clock enable low for three cycles mid-scan.
    bus.out_rdy = 1'b1;
    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = N'($urandom);
    send(v, 1'b1);
    n = 0;
    while (!bus.out_vld && n < 200) begin
      ce = (n >= 3 && n < 6) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    ce = 1'b1;
    check("ce_latency", n, NUM_CLASSES - 1 + 3);
    drain();

    // Reset in the middle of a scan discards the pending result.
    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = N'($urandom);
    send(v, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_vld", {31'd0, bus.out_vld}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = N'(1);
    v[0*N +: N] = N'(5); v[1*N +: N] = N'(40); v[2*N +: N] = N'(12); v[3*N +: N] = N'(40);
    v[9*N +: N] = N'(-3);
    send(v, 1'b1);
    drain();
    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = N'(0);
    v[0*N +: N] = N'(100); v[1*N +: N] = N'(-100);
    send(v, 1'b1);
    drain();

    // Hold with ready low for 20 cycles; a vector offered meanwhile is dropped.
    bus.out_rdy = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) v[k*N +: N] = N'($urandom);
    send(v, 1'b1);
    wait_vld(n);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        for (int k = 0; k < NUM_CLASSES; k++) v2[k*N +: N] = N'($urandom);
        send(v2, 1'b0);
      end else begin
        tick();
      end
      check("hold_vld", {31'd0, bus.out_vld}, 32'd1);
    end
    check("hold_drop_err", {31'd0, drop_err}, 32'd1);
    drain();
    check("drop_sticky", {31'd0, drop_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("drop_cleared", {31'd0, drop_err}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mnist_argmax.md
# mnist_argmax

Classification back-end placed directly downstream of the four-layer depthwise-separable MNIST network. It captures the final 10-lane score vector (one signed N-bit logit per digit class) when the last conv stage asserts valid. It then scans the lanes serially to find the maximum and presents the winning class index and score on a valid/ready output port. The result is held until the consumer accepts it.

## Interface
Parameters:
- N, 8, width of one signed score lane
- NUM_CLASSES, 10, number of score lanes (matches final conv output channels)
- CLASS_W, 4, width of class index, equal to $clog2(NUM_CLASSES)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; when low, all state is frozen
- in_vld  in  1  score vector valid (driven by the network's conv_dout_vld)
- in_din  in  NUM_CLASSES*N  packed scores; lane k is in_din[k*N +: N], two's complement
- out_vld  out  1  result valid
- out_rdy  in  1  consumer ready
- out_class  out  CLASS_W  index of the maximum lane
- out_score  out  N  score of the maximum lane
- busy  out  1  high in SCAN or DONE
- drop_err  out  1  sticky flag: a vector arrived while the block could not accept it

## Operation
- FSM states are IDLE, SCAN and DONE. Reset enters IDLE.
- Every transition below requires ce=1.
- IDLE, when in_vld=1:
  - latch in_din into vec_q
  - set best_score to lane 0 and best_idx to 0
  - set scan idx to 1
  - go to SCAN
- SCAN, each cycle:
  - compare lane idx against best_score as signed values
  - replace the best only when lane > best (strict), so ties resolve to the lowest index
  - increment idx
  - after idx = NUM_CLASSES-1 is compared, go to DONE
- DONE: out_vld=1 and out_class/out_score are driven from the best registers.
  - out_vld && out_rdy with in_vld=0: go to IDLE.
  - out_vld && out_rdy with in_vld=1 in the same cycle: the new vector is captured, as in IDLE, and the FSM goes directly to SCAN (no bubble).
- drop_err is set when in_vld=1 in SCAN, or in DONE without a completing handshake. The vector is discarded and drop_err stays set until rst.
- Arithmetic: all comparisons are signed N-bit. No widening is needed, because no sums are formed.

## Timing
- Reset values: out_vld=0, out_class=0, out_score=0, busy=0, drop_err=0. vec_q, idx and the best registers are cleared to 0.
- Latency: with the vector captured at edge T and ce held high, out_vld rises after edge T+NUM_CLASSES-1. For NUM_CLASSES=10 that is 9 SCAN cycles, so out_vld is first seen in cycle T+10.
- ce=0 at any point stalls the FSM, idx and the handshake; out_vld and the outputs hold their values. A handshake completes only on a ce=1 cycle.
- out_class and out_score are stable for as long as out_vld=1 and out_rdy=0.
- Asserting rst mid-SCAN or in DONE returns the block to IDLE on the next edge; the pending result is lost.
- Throughput: one vector per NUM_CLASSES cycles at most, when out_rdy is held high.

## Configuration
- MNIST_ARGMAX_TOP2_EN
  - Defined: the block also tracks the runner-up. It adds outputs out_class2 (CLASS_W) and out_margin (N+1, unsigned, equal to best − second). In SCAN, a new best demotes the old best to second; otherwise a lane > second (strict) replaces the second. Both new outputs reset to 0 and follow the same valid/hold rules.
  - Undefined: neither port nor its logic exists. Latency is identical in both builds.

## Structure
- Shared package mnist_pkg holds:
  - NUM_CLASSES and CLASS_W constants
  - the FSM state enum (IDLE, SCAN, DONE)
  - a signed score typedef of width N
- One sub-module, mnist_argmax_cmp: a registered-free, signed compare-and-select of a candidate {score, idx} against the current best. The TOP2 build instantiates it twice.

## Test plan
- Scores lane k = k (lane 9 = 9), out_rdy=1 → out_vld in cycle T+10, out_class=9, out_score=9.
- All lanes = −128 except lane 3 = −1 → out_class=3, out_score=0xFF. Lanes 2 and 7 both equal to 127 → out_class=2 (tie goes to the lowest index).
- out_rdy held low 20 cycles after the result appears → outputs stable and out_vld high throughout. Second in_vld during the hold → drop_err=1, with the first result unchanged.
- Back-to-back: in_vld on the exact cycle of the handshake completion → no drop, and the second result appears 10 cycles later.
- ce toggled low for 3 cycles mid-SCAN → out_vld delayed by exactly 3 cycles, with the correct result. rst pulsed mid-SCAN → busy=0 and out_vld=0 next cycle.
- TOP2 build with lanes {5, 40, 12, 40, …, −3}: out_class=1, out_class2=3, out_margin=0. With {100, −100, 0, …}: out_margin=100.
